btb_update_unit: RTL
====================

# btb_update_unit

Branch-resolution side of the fetch predictor: takes each resolved branch/jump from the resolve stage, compares its actual next PC against the PC fetch predicted, and drives the BTB write port, the global 2-bit counter update, and the fetch redirect/flush. It is the write/correct half of the predictor: fetch reads BTB entries and the counter, this block writes them.

## Interface
Parameters:
- WORD_SIZE, 16, PC/target width
- INDEX_BITS, 8, BTB index width; tag width = WORD_SIZE-INDEX_BITS
- FLUSH_CYCLES, 2, cycles `flush` stays high after a mispredict (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  pipeline stall; resolution input not consumed while high
- res_valid  in  1  a resolved instruction is presented
- res_is_bj  in  1  instruction is a branch or jump
- res_is_cond  in  1  conditional branch (BNE/BEQ/BGZ/BLZ)
- res_taken  in  1  branch condition true (jumps: 1)
- res_pc  in  WORD_SIZE  PC of resolved instruction
- res_target  in  WORD_SIZE  computed taken target
- pred_next_pc  in  WORD_SIZE  next PC fetch used after res_pc
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  WORD_SIZE  correct next PC
- flush  out  1  squash younger instructions
- btb_we  out  1  BTB write strobe
- btb_index  out  INDEX_BITS  res_pc[INDEX_BITS-1:0]
- btb_tag  out  WORD_SIZE-INDEX_BITS  res_pc upper bits
- btb_target  out  WORD_SIZE  target to store; 16'hFFFF = invalid entry
- ctr_update  out  1  counter update strobe
- update_taken  out  1  direction for counter update
- branch_count  out  16  resolved conditional branches, saturating
- mispredict_count  out  16  mispredicts, saturating

## Operation
- Accept = res_valid & res_is_bj & ~stall & state==IDLE. Non-BJ or stalled inputs: no effect.
- actual_next = res_taken ? res_target : res_pc+1 (16-bit, wraps FFFF→0000).
- mispredict = accept & (actual_next != pred_next_pc).
- BTB write on accept: taken → btb_target=res_target; not taken and pred_next_pc != res_pc+1 → btb_target=16'hFFFF (invalidate); otherwise btb_we=0.
- Counter: ctr_update=1, update_taken=res_taken on accept with res_is_cond only. Jumps never touch the counter.
- branch_count +1 per accepted conditional; mispredict_count +1 per mispredict; both hold at 16'hFFFF.
- FSM: IDLE → FLUSH on mispredict, loading flush counter FLUSH_CYCLES-1; FLUSH decrements each cycle (stall does not freeze it); counter==0 → IDLE. In FLUSH, resolution inputs are squashed wrong-path instructions: ignored entirely (no BTB write, no counter update, no count).
- Reset: state IDLE; all outputs 0 including counters, redirect_pc=0, btb_target=0.

## Timing
- All outputs registered; latency 1 cycle from accept edge.
- redirect_valid, btb_we, ctr_update: single-cycle pulses, never held.
- flush asserts same cycle as redirect_valid, stays high exactly FLUSH_CYCLES cycles.
- Back-to-back accepts in IDLE without mispredict: one write/update per cycle, no bubbles.
- reset asserted mid-FLUSH: next cycle flush=0, state IDLE; reset has priority over every input.
- Mispredict with stall=1 same cycle: not accepted, no redirect until stall drops.

## Structure
- Shared package/`opcodes.v`: WORD_SIZE, BTB invalid marker 16'hFFFF, FSM state encodings (IDLE, FLUSH).
- One sub-module natural: `sat_counter16` (enable, saturating at FFFF, sync reset), instanced twice.

## Test plan
- Reset: reset=1 two cycles → all outputs 0, flush=0.
- Correct taken prediction: res_pc=0x0010, target=0x0040, taken=1, pred=0x0040, cond → next cycle btb_we=1, index=0x10, tag=0x00, target=0x0040, ctr_update=1/update_taken=1, no redirect, branch_count=1.
- Mispredict not taken: res_pc=0x1234, taken=0, pred=0x0050 → redirect_pc=0x1235, flush high 2 cycles, btb_target=0xFFFF, tag=0x12, mispredict_count=1; valid input during flush ignored.
- Wrap: res_pc=0xFFFF, taken=0, pred=0x0000 → no redirect, btb_we=0.
- Jump: res_is_cond=0, taken=1, target=0x0100, pred=0x0021 → redirect 0x0100, btb write, ctr_update=0, branch_count unchanged.
- Stall + reset mid-flush: mispredict with stall=1 → no response; release → redirect; assert reset on first flush cycle → flush=0 next cycle.

Source files
------------

// File: rtl/btb_update_unit_pkg.sv
// Shared constants and types for the BTB update (branch resolution) unit.
// Default widths, the BTB invalid-entry marker and the resolve FSM states.
package btb_update_unit_pkg;

    localparam int unsigned DEF_WORD_SIZE  = 16;
    localparam int unsigned DEF_INDEX_BITS = 8;
    localparam int unsigned STAT_BITS      = 16;

    localparam logic [DEF_WORD_SIZE-1:0] BTB_INVALID = 16'hFFFF;
    localparam logic [STAT_BITS-1:0]     STAT_MAX    = 16'hFFFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/btb_update_unit_if.sv
// Resolve-stage inputs and BTB/counter/fetch-redirect outputs of the update unit.
// Signal directions are named from the update unit's point of view.
interface btb_update_unit_if
    import btb_update_unit_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int INDEX_BITS = DEF_INDEX_BITS
);
    logic                          i_stall;
    logic                          i_res_valid;
    logic                          i_res_is_bj;
    logic                          i_res_is_cond;
    logic                          i_res_taken;
    logic [WORD_SIZE-1:0]          i_res_pc;
    logic [WORD_SIZE-1:0]          i_res_target;
    logic [WORD_SIZE-1:0]          i_pred_next_pc;

    logic                          o_redirect_valid;
    logic [WORD_SIZE-1:0]          o_redirect_pc;
    logic                          o_flush;
    logic                          o_btb_we;
    logic [INDEX_BITS-1:0]         o_btb_index;
    logic [WORD_SIZE-INDEX_BITS-1:0] o_btb_tag;
    logic [WORD_SIZE-1:0]          o_btb_target;
    logic                          o_ctr_update;
    logic                          o_update_taken;
    logic [STAT_BITS-1:0]          o_branch_count;
    logic [STAT_BITS-1:0]          o_mispredict_count;

    modport master (
        output i_stall, i_res_valid, i_res_is_bj, i_res_is_cond, i_res_taken,
               i_res_pc, i_res_target, i_pred_next_pc,
        input  o_redirect_valid, o_redirect_pc, o_flush, o_btb_we, o_btb_index,
               o_btb_tag, o_btb_target, o_ctr_update, o_update_taken,
               o_branch_count, o_mispredict_count
    );

    modport slave (
        input  i_stall, i_res_valid, i_res_is_bj, i_res_is_cond, i_res_taken,
               i_res_pc, i_res_target, i_pred_next_pc,
        output o_redirect_valid, o_redirect_pc, o_flush, o_btb_we, o_btb_index,
               o_btb_tag, o_btb_target, o_ctr_update, o_update_taken,
               o_branch_count, o_mispredict_count
    );

endinterface

// File: rtl/btb_update_unit_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module btb_update_unit_sat_counter16
    import btb_update_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    output logic [STAT_BITS-1:0] o_count
);

    logic [STAT_BITS-1:0] r_count;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != STAT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/btb_update_unit.sv
// Resolves branches/jumps against the fetch prediction: writes the BTB, updates the
// global direction counter, and redirects/flushes fetch on a mispredict.
module btb_update_unit
    import btb_update_unit_pkg::*;
#(
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int INDEX_BITS   = DEF_INDEX_BITS,
    parameter int FLUSH_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              reset,
    btb_update_unit_if.slave  bus
);

    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
    localparam int FC_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]      FC_LOAD      = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WORD_SIZE-1:0] INVALID_MARK = {WORD_SIZE{1'b1}};

    state_e              r_state;
    state_e              w_next_state;
    logic [FC_W-1:0]     r_flush_cnt;
    logic [FC_W-1:0]     w_next_flush_cnt;

    logic                w_accept;
    logic                w_mispredict;
    logic                w_btb_write;
    logic                w_ctr_write;
    logic [WORD_SIZE-1:0] w_seq_pc;
    logic [WORD_SIZE-1:0] w_actual_next;

    logic                 r_redirect_valid;
    logic [WORD_SIZE-1:0] r_redirect_pc;
    logic                 r_flush;
    logic                 r_btb_we;
    logic [INDEX_BITS-1:0] r_btb_index;
    logic [TAG_BITS-1:0]  r_btb_tag;
    logic [WORD_SIZE-1:0] r_btb_target;
    logic                 r_ctr_update;
    logic                 r_update_taken;
    logic [STAT_BITS-1:0] w_branch_count;
    logic [STAT_BITS-1:0] w_mispredict_count;

    // Wrong-path instructions arriving during FLUSH never reach any side effect.
    assign w_accept      = bus.i_res_valid & bus.i_res_is_bj & ~bus.i_stall & (r_state == ST_IDLE);
    assign w_seq_pc      = bus.i_res_pc + WORD_SIZE'(1);
    assign w_actual_next = bus.i_res_taken ? bus.i_res_target : w_seq_pc;
    assign w_mispredict  = w_accept & (w_actual_next != bus.i_pred_next_pc);
    // Not-taken entries are only invalidated when fetch actually predicted a jump away.
    assign w_btb_write   = w_accept & (bus.i_res_taken | (bus.i_pred_next_pc != w_seq_pc));
    assign w_ctr_write   = w_accept & bus.i_res_is_cond;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_flush_cnt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state     = r_state;
        w_next_flush_cnt = r_flush_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_mispredict) begin
                    w_next_state     = ST_FLUSH;
                    w_next_flush_cnt = FC_LOAD;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_flush_cnt = r_flush_cnt - 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_btb_we         <= 1'b0;
            r_btb_index      <= '0;
            r_btb_tag        <= '0;
            r_btb_target     <= '0;
            r_ctr_update     <= 1'b0;
            r_update_taken   <= 1'b0;
        end else begin
            r_redirect_valid <= w_mispredict;
            r_flush          <= (w_next_state == ST_FLUSH);
            r_btb_we         <= w_btb_write;
            r_ctr_update     <= w_ctr_write;
            if (w_mispredict) begin
                r_redirect_pc <= w_actual_next;
            end
            if (w_btb_write) begin
                r_btb_index  <= bus.i_res_pc[INDEX_BITS-1:0];
                r_btb_tag    <= bus.i_res_pc[WORD_SIZE-1:INDEX_BITS];
                r_btb_target <= bus.i_res_taken ? bus.i_res_target : INVALID_MARK;
            end
            if (w_ctr_write) begin
                r_update_taken <= bus.i_res_taken;
            end
        end
    end

    btb_update_unit_sat_counter16 u_branch_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_ctr_write),
        .o_count (w_branch_count)
    );

    btb_update_unit_sat_counter16 u_mispredict_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_mispredict),
        .o_count (w_mispredict_count)
    );

    assign bus.o_redirect_valid   = r_redirect_valid;
    assign bus.o_redirect_pc      = r_redirect_pc;
    assign bus.o_flush            = r_flush;
    assign bus.o_btb_we           = r_btb_we;
    assign bus.o_btb_index        = r_btb_index;
    assign bus.o_btb_tag          = r_btb_tag;
    assign bus.o_btb_target       = r_btb_target;
    assign bus.o_ctr_update       = r_ctr_update;
    assign bus.o_update_taken     = r_update_taken;
    assign bus.o_branch_count     = w_branch_count;
    assign bus.o_mispredict_count = w_mispredict_count;

endmodule
